// File: rtl/daq_pkg.sv
// Shared definitions for the trigger acceptance controller: state encoding,
// default timing parameters, counter widths and the dead-time helper.
package daq_pkg;

    // Controller states; IDLE is the only state in which a trigger is accepted.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DEAD      = 2'd3
    } state_e;

    localparam int unsigned DEAD_MIN_DEF = 32'd16;
    localparam int unsigned TMO_CYC_DEF  = 32'd65536;
    localparam int unsigned TS_W_DEF     = 32'd32;

    localparam int unsigned NUM_W  = 32'd32;
    localparam int unsigned LOST_W = 32'd16;
    localparam int unsigned DEAD_W = 32'd16;

    // Effective dead time: the programmed value, floored at the minimum.
    function automatic logic [DEAD_W-1:0] dead_eff(
        input logic [DEAD_W-1:0] cfg,
        input logic [DEAD_W-1:0] dmin
    );
        logic [DEAD_W-1:0] res;
        if (cfg < dmin) begin
            res = dmin;
        end else begin
            res = cfg;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
    parameter int unsigned W = 32'd16
) (
    input  logic         init_clk,
    input  logic         reset_i,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_r;

    // Count increment requests until the maximum value is reached.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/trig_sched.sv
// Trigger acceptance controller: accepts one generator trigger at a time,
// stamps it, runs the readout req/ack/done handshake, applies dead time and
// counts triggers that arrive while a previous one is still being handled.
module trig_sched
    import daq_pkg::*;
#(
    parameter int unsigned DEAD_MIN = DEAD_MIN_DEF,
    parameter int unsigned TMO_CYC  = TMO_CYC_DEF,
    parameter int unsigned TS_W     = TS_W_DEF
) (
    input  logic              init_clk,
    input  logic              reset_i,
    input  logic              enable,
    input  logic              trig_in,
    input  logic [DEAD_W-1:0] dead_cfg,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              rd_req,
    output logic              trig_stun,
    output logic              busy,
    output logic [NUM_W-1:0]  trig_num,
    output logic [TS_W-1:0]   trig_ts,
    output logic [LOST_W-1:0] lost_cnt,
    output logic              tmo_flag
);

    localparam int unsigned       TMO_W      = (TMO_CYC > 32'd1) ? $clog2(TMO_CYC) : 32'd1;
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TMO_CYC - 32'd1);
    localparam logic [DEAD_W-1:0] DEAD_MIN_L = DEAD_W'(DEAD_MIN);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [TS_W-1:0]    ts_r;
    logic               trig_in_d_r;
    logic               edge_s;
    logic               accept_s;
    logic               load_dead_s;
    logic               tmo_hit_s;
    logic               lost_inc_s;
    logic               busy_s;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [DEAD_W-1:0]  dcnt_r;
    logic               rd_req_r;
    logic               trig_stun_r;
    logic [NUM_W-1:0]   trig_num_r;
    logic [TS_W-1:0]    trig_ts_r;
    logic               tmo_flag_r;

    assign edge_s     = trig_in & ~trig_in_d_r;
    assign busy_s     = (state_r != ST_IDLE);
    assign lost_inc_s = edge_s & enable & busy_s;

    // State register.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus the one-cycle strobes that drive the datapath.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        load_dead_s = 1'b0;
        tmo_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (edge_s && enable) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rd_ack && rd_done) begin
                    load_dead_s = 1'b1;
                    state_nxt_s = ST_DEAD;
                end else if (rd_ack) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT_DONE: begin
                if (rd_done) begin
                    load_dead_s = 1'b1;
                    state_nxt_s = ST_DEAD;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_hit_s   = 1'b1;
                    load_dead_s = 1'b1;
                    state_nxt_s = ST_DEAD;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_DEAD: begin
                // A count of 1 is the last dead cycle; <= also guards a zero load.
                if (dcnt_r <= DEAD_W'(1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DEAD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Free-running timestamp and trigger edge history.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            ts_r        <= {TS_W{1'b0}};
            trig_in_d_r <= 1'b0;
        end else begin
            ts_r        <= ts_r + TS_W'(1);
            trig_in_d_r <= trig_in;
        end
    end

    // Event number and timestamp captured on acceptance.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            trig_num_r <= {NUM_W{1'b0}};
            trig_ts_r  <= {TS_W{1'b0}};
        end else if (accept_s) begin
            trig_num_r <= trig_num_r + NUM_W'(1);
            trig_ts_r  <= ts_r;
        end else begin
            trig_num_r <= trig_num_r;
            trig_ts_r  <= trig_ts_r;
        end
    end

    // Readout timeout counter; held at zero outside WAIT_DONE so entry starts at 0.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_WAIT_DONE) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    // Dead-time countdown, loaded on the transition into DEAD.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            dcnt_r <= {DEAD_W{1'b0}};
        end else if (load_dead_s) begin
            dcnt_r <= dead_eff(dead_cfg, DEAD_MIN_L);
        end else if (state_r == ST_DEAD) begin
            dcnt_r <= dcnt_r - DEAD_W'(1);
        end else begin
            dcnt_r <= dcnt_r;
        end
    end

    // Registered handshake, stun and sticky timeout outputs.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            rd_req_r    <= 1'b0;
            trig_stun_r <= 1'b0;
            tmo_flag_r  <= 1'b0;
        end else begin
            rd_req_r    <= (state_nxt_s == ST_REQ);
            trig_stun_r <= busy_s | ~enable;
            tmo_flag_r  <= tmo_flag_r | tmo_hit_s;
        end
    end

    sat_cnt #(
        .W (LOST_W)
    ) u_lost_cnt (
        .init_clk (init_clk),
        .reset_i  (reset_i),
        .inc      (lost_inc_s),
        .cnt      (lost_cnt)
    );

    assign rd_req    = rd_req_r;
    assign trig_stun = trig_stun_r;
    assign busy      = busy_s;
    assign trig_num  = trig_num_r;
    assign trig_ts   = trig_ts_r;
    assign tmo_flag  = tmo_flag_r;

endmodule

// File: tb/tb_trig_sched.sv
// Self-checking bench for trig_sched: a directed cycle table, hand-written
// corner sequences, then randomized traffic against an event-level model.
module tb_trig_sched;

    localparam int unsigned TMO  = 32'd100;
    localparam int unsigned DMIN = 32'd16;
    localparam int unsigned TSW  = 32'd32;

    logic        init_clk = 1'b0;
    logic        reset_i  = 1'b1;
    logic        enable   = 1'b1;
    logic        trig_in  = 1'b0;
    logic [15:0] dead_cfg = 16'd0;
    logic        rd_ack   = 1'b0;
    logic        rd_done  = 1'b0;
    logic        rd_req;
    logic        trig_stun;
    logic        busy;
    logic [31:0] trig_num;
    logic [31:0] trig_ts;
    logic [15:0] lost_cnt;
    logic        tmo_flag;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state (values visible after the latest clock edge).
    int          m_phase;   // 0 idle, 1 request, 2 waiting for done, 3 dead
    int          m_age;
    int          m_left;
    int          m_lost;
    logic [31:0] m_num;
    logic [31:0] m_tsl;
    logic [31:0] m_ts;
    logic        m_prev;
    logic        m_req;
    logic        m_stun;
    logic        m_tmo;

    typedef struct {
        logic        trig;
        logic        ack;
        logic        done;
        int          n;
        logic        e_req;
        logic        e_busy;
        logic        e_stun;
        logic [31:0] e_num;
    } vec_t;

    vec_t tbl [9];

    trig_sched #(
        .DEAD_MIN (DMIN),
        .TMO_CYC  (TMO),
        .TS_W     (TSW)
    ) dut (
        .init_clk  (init_clk),
        .reset_i   (reset_i),
        .enable    (enable),
        .trig_in   (trig_in),
        .dead_cfg  (dead_cfg),
        .rd_ack    (rd_ack),
        .rd_done   (rd_done),
        .rd_req    (rd_req),
        .trig_stun (trig_stun),
        .busy      (busy),
        .trig_num  (trig_num),
        .trig_ts   (trig_ts),
        .lost_cnt  (lost_cnt),
        .tmo_flag  (tmo_flag)
    );

    // Free-running clock, 10 time-unit period.
    always #5 init_clk = ~init_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic rst, input logic trig, input logic en,
                              input logic ack, input logic done, input logic [15:0] dcfg);
        logic edge_seen;
        logic stun_n;
        int   dlen;
        if (rst) begin
            m_phase = 0; m_age = 0; m_left = 0; m_lost = 0;
            m_num = 32'd0; m_tsl = 32'd0; m_ts = 32'd0;
            m_prev = 1'b0; m_req = 1'b0; m_stun = 1'b0; m_tmo = 1'b0;
            return;
        end
        edge_seen = trig && !m_prev;
        stun_n    = (m_phase != 0) || !en;
        dlen      = (int'(dcfg) > int'(DMIN)) ? int'(dcfg) : int'(DMIN);
        if (edge_seen && en && m_phase != 0 && m_lost < 65535) m_lost++;
        case (m_phase)
            0: if (edge_seen && en) begin
                   m_num = m_num + 32'd1; m_tsl = m_ts; m_phase = 1;
               end
            1: if (ack) begin
                   if (done) begin m_phase = 3; m_left = dlen; end
                   else begin m_phase = 2; m_age = 0; end
               end
            2: if (done) begin
                   m_phase = 3; m_left = dlen;
               end else if (m_age == int'(TMO) - 1) begin
                   m_tmo = 1'b1; m_phase = 3; m_left = dlen;
               end else begin
                   m_age++;
               end
            3: begin
                   m_left--;
                   if (m_left == 0) m_phase = 0;
               end
            default: m_phase = 0;
        endcase
        m_req  = (m_phase == 1);
        m_ts   = m_ts + 32'd1;
        m_prev = trig;
        m_stun = stun_n;
    endtask

    // Apply inputs for one cycle, step the model, sample 1 unit after the edge.
    task automatic cyc(input logic rst, input logic trig, input logic en,
                       input logic ack, input logic done, input logic [15:0] dcfg);
        reset_i  = rst;
        trig_in  = trig;
        enable   = en;
        rd_ack   = ack;
        rd_done  = done;
        dead_cfg = dcfg;
        model_step(rst, trig, en, ack, done, dcfg);
        @(posedge init_clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        reset_i = 1'b0;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".rd_req"},    {63'd0, rd_req},    {63'd0, m_req});
        chk({tag, ".busy"},      {63'd0, busy},      {63'd0, (m_phase != 0)});
        chk({tag, ".trig_stun"}, {63'd0, trig_stun}, {63'd0, m_stun});
        chk({tag, ".trig_num"},  {32'd0, trig_num},  {32'd0, m_num});
        chk({tag, ".trig_ts"},   {32'd0, trig_ts},   {32'd0, m_tsl});
        chk({tag, ".lost_cnt"},  {48'd0, lost_cnt},  64'(m_lost));
        chk({tag, ".tmo_flag"},  {63'd0, tmo_flag},  {63'd0, m_tmo});
    endtask

    // Test sequence: table, corner sequences, randomized run, summary.
    initial begin
        logic r_trig;
        // trig, ack, done, n, e_req, e_busy, e_stun, e_num
        tbl[0] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 32'd1};
        tbl[2] = '{1'b0, 1'b0, 1'b0,  2, 1'b1, 1'b1, 1'b1, 32'd1};
        tbl[3] = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b1, 32'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0,  6, 1'b0, 1'b1, 1'b1, 32'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b1, 32'd1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 31, 1'b0, 1'b1, 1'b1, 32'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 32'd1};
        tbl[8] = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 32'd1};

        // Reset state
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("rst.rd_req",    {63'd0, rd_req},    64'd0);
        chk("rst.busy",      {63'd0, busy},      64'd0);
        chk("rst.trig_stun", {63'd0, trig_stun}, 64'd0);
        chk("rst.trig_num",  {32'd0, trig_num},  64'd0);
        chk("rst.trig_ts",   {32'd0, trig_ts},   64'd0);
        chk("rst.lost_cnt",  {48'd0, lost_cnt},  64'd0);
        chk("rst.tmo_flag",  {63'd0, tmo_flag},  64'd0);

        // Basic transaction: trigger at cycle 10, ack 13, done 20, dead 32
        do_reset();
        for (int r = 0; r < 9; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                cyc(1'b0, tbl[r].trig, 1'b1, tbl[r].ack, tbl[r].done, 16'd32);
                chk($sformatf("tbl%0d.rd_req", r),    {63'd0, rd_req},    {63'd0, tbl[r].e_req});
                chk($sformatf("tbl%0d.busy", r),      {63'd0, busy},      {63'd0, tbl[r].e_busy});
                chk($sformatf("tbl%0d.trig_stun", r), {63'd0, trig_stun}, {63'd0, tbl[r].e_stun});
                chk($sformatf("tbl%0d.trig_num", r),  {32'd0, trig_num},  {32'd0, tbl[r].e_num});
            end
        end
        chk("tbl.trig_ts", {32'd0, trig_ts}, 64'd10);

        // Long trigger level: one acceptance only
        do_reset();
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 1'b1, 1'b1, (k == 2), (k == 10), 16'd0);
        end
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("long.trig_num", {32'd0, trig_num}, 64'd1);
        chk("long.lost_cnt", {48'd0, lost_cnt}, 64'd0);
        chk("long.busy",     {63'd0, busy},     64'd0);

        // Three extra edges during WAIT_DONE
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, (k % 2 == 0), 1'b1, 1'b0, 1'b0, 16'd0);
            chk("lost.trig_stun", {63'd0, trig_stun}, 64'd1);
        end
        chk("lost.lost_cnt", {48'd0, lost_cnt}, 64'd3);
        chk("lost.trig_num", {32'd0, trig_num}, 64'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
        for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("lost.idle", {63'd0, busy}, 64'd0);

        // Readout timeout: no rd_done for TMO cycles
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 99; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("tmo.before", {63'd0, tmo_flag}, 64'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("tmo.flag", {63'd0, tmo_flag}, 64'd1);
        chk("tmo.busy", {63'd0, busy},     64'd1);
        for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("tmo.idle", {63'd0, busy}, 64'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("tmo.next_req", {63'd0, rd_req},   64'd1);
        chk("tmo.next_num", {32'd0, trig_num}, 64'd3);

        // dead_cfg=0 with ack and done together: 16 DEAD cycles, no WAIT_DONE
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0);
        chk("dmin.rd_req", {63'd0, rd_req}, 64'd0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
            chk($sformatf("dmin.busy%0d", k), {63'd0, busy}, {63'd0, (k < 15)});
        end
        chk("dmin.tmo_sticky", {63'd0, tmo_flag}, 64'd1);

        // Reset while in REQ
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("mid.rd_req",   {63'd0, rd_req},   64'd0);
        chk("mid.busy",     {63'd0, busy},     64'd0);
        chk("mid.trig_num", {32'd0, trig_num}, 64'd0);
        chk("mid.lost_cnt", {48'd0, lost_cnt}, 64'd0);
        chk("mid.tmo_flag", {63'd0, tmo_flag}, 64'd0);

        // Edges while disabled, and a level already high when enable rises
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("dis.trig_stun", {63'd0, trig_stun}, 64'd1);
        chk("dis.busy",      {63'd0, busy},      64'd0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("dis.trig_num", {32'd0, trig_num}, 64'd0);
        chk("dis.lost_cnt", {48'd0, lost_cnt}, 64'd0);
        chk("dis.rd_req",   {63'd0, rd_req},   64'd0);

        // Randomized traffic against the model
        do_reset();
        r_trig = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) r_trig = ~r_trig;
            cyc(($urandom_range(0, 799) == 0), r_trig, ($urandom_range(0, 15) != 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 29) == 0),
                16'($urandom_range(0, 40)));
            cmp_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
